// File: rtl/simple_spi_s_bit_rw.sv
// SPI mode-0 slave (responder), counterpart to simple_spi_m_bit_rw.
// spi_clk, cs and mosi are oversampled in the sys_clk domain. Each pin edge acts
// three sys_clk cycles after it occurs. sys_clk must run at least 8x spi_clk.
// Optional build macro: SPI_S_LSB_FIRST_EN selects LSB-first transfers.
// When it is undefined, transfers are MSB-first, matching the master.

module simple_spi_s_bit_rw #(
    parameter int unsigned reg_width = 8
) (
    input  logic                       sys_clk,
    input  logic                       rstn,
    input  logic                       spi_clk,
    input  logic                       cs,
    input  logic                       mosi,
    output logic                       miso,
    input  logic [reg_width-1:0]       d_in,
    input  logic [$clog2(reg_width):0] t_size,
    output logic [reg_width-1:0]       d_out,
    output logic                       rx_valid,
    output logic                       busy
);

    localparam int unsigned SizeW = $clog2(reg_width) + 1;
    localparam int unsigned IdxW  = $clog2(reg_width);
    localparam logic [SizeW-1:0] FullSize = SizeW'(reg_width);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    // Synchroniser and edge-history registers.
    logic sclk_meta_q, sclk_sync_q, sclk_hist_q;
    logic cs_meta_q, cs_sync_q, cs_hist_q;
    logic mosi_meta_q, mosi_sync_q;

    // Transfer state.
    state_e               state_q, state_d;
    logic [reg_width-1:0] tx_q, tx_d;
    logic [reg_width-1:0] rx_q, rx_d;
    logic [SizeW-1:0]     size_q, size_d;
    logic [SizeW-1:0]     cnt_q, cnt_d;
    logic                 miso_q, miso_d;
    logic [reg_width-1:0] d_out_q, d_out_d;
    logic                 rx_valid_q, rx_valid_d;

    // Edge detection on the synchronised pins.
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    assign sclk_rise = sclk_sync_q & ~sclk_hist_q;
    assign sclk_fall = ~sclk_sync_q & sclk_hist_q;
    assign cs_rise   = cs_sync_q & ~cs_hist_q;
    assign cs_fall   = ~cs_sync_q & cs_hist_q;

    // Out-of-range sizes (0 or wider than the register) fall back to a full word.
    logic [SizeW-1:0] eff_size;
    assign eff_size = (t_size != '0 && t_size <= FullSize) ? t_size : FullSize;

    // Bit-order-dependent datapath: first tx bit, next tx bit, rx shift and alignment.
    logic                 first_bit;
    logic                 next_bit;
    logic [reg_width-1:0] rx_shift;
    logic [reg_width-1:0] rx_align;

    always_comb begin
`ifdef SPI_S_LSB_FIRST_EN
        first_bit = d_in[0];
        next_bit  = tx_q[IdxW'(cnt_q)];
        rx_shift  = {mosi_sync_q, rx_q[reg_width-1:1]};
        // Bits enter at the top, so a short word has to be pulled down to bit 0.
        rx_align  = rx_shift >> (FullSize - size_q);
`else
        first_bit = d_in[IdxW'(eff_size - SizeW'(1))];
        next_bit  = tx_q[IdxW'(size_q - cnt_q - SizeW'(1))];
        rx_shift  = {rx_q[reg_width-2:0], mosi_sync_q};
        rx_align  = rx_shift;
`endif
    end

    // Pin synchronisers; presets match the idle bus (clock low, cs high).
    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            sclk_meta_q <= 1'b0;
            sclk_sync_q <= 1'b0;
            sclk_hist_q <= 1'b0;
            cs_meta_q   <= 1'b1;
            cs_sync_q   <= 1'b1;
            cs_hist_q   <= 1'b1;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
        end else begin
            sclk_meta_q <= spi_clk;
            sclk_sync_q <= sclk_meta_q;
            sclk_hist_q <= sclk_sync_q;
            cs_meta_q   <= cs;
            cs_sync_q   <= cs_meta_q;
            cs_hist_q   <= cs_sync_q;
            mosi_meta_q <= mosi;
            mosi_sync_q <= mosi_meta_q;
        end
    end

    // Transfer FSM: next state and datapath updates.
    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        size_d     = size_q;
        cnt_d      = cnt_q;
        miso_d     = miso_q;
        d_out_d    = d_out_q;
        rx_valid_d = 1'b0;

        case (state_q)
            StIdle: begin
                miso_d = 1'b0;
                if (cs_fall) begin
                    tx_d    = d_in;
                    size_d  = eff_size;
                    cnt_d   = '0;
                    rx_d    = '0;
                    miso_d  = first_bit;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (sclk_rise) begin
                    rx_d  = rx_shift;
                    cnt_d = cnt_q + SizeW'(1);
                    if (cnt_q == size_q - SizeW'(1)) begin
                        d_out_d    = rx_align;
                        rx_valid_d = 1'b1;
                        state_d    = StDone;
                    end
                end else if (sclk_fall) begin
                    miso_d = next_bit;
                end
                // A cs rise in the same cycle as the final rise still completes the word.
                if (cs_rise) begin
                    state_d = StIdle;
                    miso_d  = 1'b0;
                end
            end
            StDone: begin
                if (cs_rise) begin
                    state_d = StIdle;
                    miso_d  = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                miso_d  = 1'b0;
            end
        endcase
    end

    // Transfer state registers.
    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            state_q    <= StIdle;
            tx_q       <= '0;
            rx_q       <= '0;
            size_q     <= '0;
            cnt_q      <= '0;
            miso_q     <= 1'b0;
            d_out_q    <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            size_q     <= size_d;
            cnt_q      <= cnt_d;
            miso_q     <= miso_d;
            d_out_q    <= d_out_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign miso     = miso_q;
    assign d_out    = d_out_q;
    assign rx_valid = rx_valid_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_simple_spi_s_bit_rw.sv
// Bench for simple_spi_s_bit_rw: a mode-0 master drives directed and random transfers.
// The reference model treats every transfer as "low eff bits of each word".
// Under that model, d_out is the master word masked to eff bits.
// The word the master collects is d_in masked to eff bits.

module tb_simple_spi_s_bit_rw;

    localparam int W    = 8;
    localparam int HALF = 8;  // sys_clk cycles per spi_clk half period

    logic         sys_clk = 1'b0;
    logic         rstn    = 1'b0;
    logic         spi_clk = 1'b0;
    logic         cs      = 1'b1;
    logic         mosi    = 1'b0;
    logic         miso;
    logic [W-1:0] d_in    = '0;
    logic [3:0]   t_size  = 4'd8;
    logic [W-1:0] d_out;
    logic         rx_valid;
    logic         busy;

    int           n_vec     = 0;
    int           n_err     = 0;
    int           vcnt      = 0;
    logic [W-1:0] exp_d_out = '0;

    always #5 sys_clk = ~sys_clk;

    simple_spi_s_bit_rw #(.reg_width(W)) dut (
        .sys_clk  (sys_clk),
        .rstn     (rstn),
        .spi_clk  (spi_clk),
        .cs       (cs),
        .mosi     (mosi),
        .miso     (miso),
        .d_in     (d_in),
        .t_size   (t_size),
        .d_out    (d_out),
        .rx_valid (rx_valid),
        .busy     (busy)
    );

    // Count sys_clk cycles with rx_valid high; one pulse per completed word is expected.
    always @(negedge sys_clk) if (rx_valid) vcnt++;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int eff_of(input logic [3:0] tsz);
        return (tsz >= 4'd1 && tsz <= 4'd8) ? int'(tsz) : W;
    endfunction

    function automatic logic [W-1:0] mask_of(input int n);
        return W'((1 << n) - 1);
    endfunction

    // Word bit carried by the i-th clock of a transfer of eff bits.
    function automatic int bit_pos(input int eff, input int i);
`ifdef SPI_S_LSB_FIRST_EN
        return i;
`else
        return eff - 1 - i;
`endif
    endfunction

    // One master transaction of nclk rising edges; simul raises cs with the last rise.
    task automatic xfer(input string tag, input logic [W-1:0] din, input logic [3:0] tsz,
                        input logic [W-1:0] word, input int nclk, input bit simul);
        int           eff;
        int           v0;
        bit           done;
        logic [W-1:0] mrx;
        logic         first;
        eff   = eff_of(tsz);
        v0    = vcnt;
        done  = (nclk >= eff);
        mrx   = '0;
        first = 1'b0;
        d_in   = din;
        t_size = tsz;
        @(negedge sys_clk);
        cs   = 1'b0;
        mosi = word[bit_pos(eff, 0)];
        repeat (4) @(negedge sys_clk);
        // Inputs are captured at cs fall; later changes must not matter.
        d_in   = W'($urandom);
        t_size = 4'($urandom);
        repeat (HALF - 4) @(negedge sys_clk);
        for (int i = 0; i < nclk; i++) begin
            if (simul && i == nclk - 1) cs = 1'b1;
            spi_clk = 1'b1;
            if (i < eff) mrx[bit_pos(eff, i)] = miso;
            if (i == 0) first = miso;
            if (!(simul && i == nclk - 1)) begin
                repeat (HALF) @(negedge sys_clk);
                spi_clk = 1'b0;
                if (i + 1 < eff) mosi = word[bit_pos(eff, i + 1)];
                repeat (HALF) @(negedge sys_clk);
            end
        end
        cs = 1'b1;
        repeat (2) @(negedge sys_clk);
        check_val({tag, " busy-hold"}, 32'(busy), 32'd1);
        @(negedge sys_clk);
        check_val({tag, " busy-drop"}, 32'(busy), 32'd0);
        spi_clk = 1'b0;
        repeat (HALF) @(negedge sys_clk);
        if (done) exp_d_out = word & mask_of(eff);
        check_val({tag, " d_out"}, 32'(d_out), 32'(exp_d_out));
        check_val({tag, " rx_valid"}, 32'(vcnt - v0), done ? 32'd1 : 32'd0);
        check_val({tag, " miso-idle"}, 32'(miso), 32'd0);
        if (nclk >= 1) check_val({tag, " first-miso"}, 32'(first), 32'(din[bit_pos(eff, 0)]));
        if (nclk == eff) check_val({tag, " master-rx"}, 32'(mrx), 32'(din & mask_of(eff)));
    endtask

    initial begin
        logic [W-1:0] rd;
        logic [W-1:0] rw;
        logic [3:0]   rt;
        int           re;
        int           rn;
        bit           rs;

        // Reset state.
        rstn = 1'b0;
        cs   = 1'b1;
        repeat (2) @(negedge sys_clk);
        check_val("rst miso", 32'(miso), 32'd0);
        check_val("rst d_out", 32'(d_out), 32'd0);
        check_val("rst rx_valid", 32'(rx_valid), 32'd0);
        check_val("rst busy", 32'(busy), 32'd0);
        rstn = 1'b1;
        repeat (4) @(negedge sys_clk);

        // Directed transfers.
        xfer("full", 8'h3c, 4'd8, 8'haa, 8, 1'b0);
        xfer("short", 8'h0b, 4'd4, 8'h05, 4, 1'b0);
        xfer("abort", 8'h55, 4'd8, 8'hff, 5, 1'b0);
        xfer("clamp0", 8'hc3, 4'd0, 8'h81, 8, 1'b0);
        xfer("clamp15", 8'h96, 4'd15, 8'h81, 8, 1'b0);
`ifdef SPI_S_LSB_FIRST_EN
        xfer("lsb", 8'h01, 4'd8, 8'h80, 8, 1'b0);
`endif
        xfer("simul-done", 8'ha5, 4'd8, 8'h3c, 8, 1'b1);
        xfer("simul-abort", 8'h5a, 4'd8, 8'h77, 5, 1'b1);
        xfer("extra-clk", 8'h5a, 4'd6, 8'h2b, 7, 1'b0);
        xfer("one-bit", 8'h01, 4'd1, 8'h01, 1, 1'b0);

        // Reset in the middle of a transfer discards the partial word.
        d_in   = 8'h77;
        t_size = 4'd8;
        @(negedge sys_clk);
        cs   = 1'b0;
        mosi = 1'b1;
        repeat (HALF) @(negedge sys_clk);
        spi_clk = 1'b1;
        repeat (HALF) @(negedge sys_clk);
        spi_clk = 1'b0;
        repeat (HALF) @(negedge sys_clk);
        rstn    = 1'b0;
        cs      = 1'b1;
        spi_clk = 1'b0;
        repeat (2) @(negedge sys_clk);
        check_val("midrst busy", 32'(busy), 32'd0);
        check_val("midrst d_out", 32'(d_out), 32'd0);
        check_val("midrst miso", 32'(miso), 32'd0);
        rstn      = 1'b1;
        exp_d_out = '0;
        repeat (HALF) @(negedge sys_clk);
        xfer("post-rst", 8'he7, 4'd8, 8'h19, 8, 1'b0);

        // Random transfers: sizes include out-of-range values; some abort early.
        for (int k = 0; k < 30; k++) begin
            rd = W'($urandom);
            rw = W'($urandom);
            rt = 4'($urandom);
            re = eff_of(rt);
            rn = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, re - 1)) : re;
            rs = (rn >= 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            xfer($sformatf("rnd%0d", k), rd, rt, rw, rn, rs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
